// File: rtl/mem_initiator.sv
// mem_initiator
// CPU-side memory master. Arbitrates round-robin between the instruction
// fetch port (read only) and the load/store port. It decodes the system
// address map, runs one bus cycle per granted request, waits for mfc and
// returns read data with a one-cycle done pulse on the winning port.
// Illegal or misaligned accesses are rejected without a bus cycle.
// Accesses whose mfc never arrives are aborted with an error.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   if_req, if_addr       : fetch request level and byte address
//   ls_req, ls_we,
//   ls_addr, ls_wdata     : load/store request level, direction, address, data
//   if_done, ls_done      : one-cycle completion pulses per port
//   rsp_err, rsp_rdata    : error flag and read data, valid with a done pulse
//   mem_address,
//   mem_wdata             : bus address and write data
//   mem_rd, mem_wr        : bus strobes, never both high
//   mem_rdata, mfc        : bus read data and memory-function-complete
module mem_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        if_done,
  output logic        ls_done,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mfc
);

  // The wait counter only ever needs to hold TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERROR
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;       // 1 = load/store granted last
  logic          is_ls_q, is_ls_d;     // port owning the current access
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [31:0]   mem_address_q, mem_address_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          if_done_q, if_done_d;
  logic          ls_done_q, ls_done_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic          grant_ls;
  logic [31:0]   sel_addr;
  logic          sel_we;

  // Reserved ranges, misalignment and writes into the read-only low
  // region (instruction memory and CSRs) are all rejected.
  function automatic logic decode_err(input logic [31:0] addr, input logic we);
    logic reserved;
    logic misaligned;
    logic ro_write;
    reserved   = ((addr >= 32'h0002_0000) && (addr <= 32'h0FFF_FFFF)) ||
                 (addr >= 32'hE000_0000);
    misaligned = (addr[1:0] != 2'b00);
    ro_write   = we && (addr < 32'h0002_0000);
    return reserved || misaligned || ro_write;
  endfunction

  // Round-robin: on contention, the port that did not win last time wins.
  assign grant_ls = ls_req && (!if_req || !last_q);
  assign sel_addr = grant_ls ? ls_addr : if_addr;
  assign sel_we   = grant_ls && ls_we;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    is_ls_d       = is_ls_q;
    cnt_d         = cnt_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_d      = mem_wr_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    if_done_d     = 1'b0;
    ls_done_d     = 1'b0;
    rsp_err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          last_d        = grant_ls;
          is_ls_d       = grant_ls;
          mem_address_d = sel_addr;
          mem_wdata_d   = grant_ls ? ls_wdata : 32'h0;
          cnt_d         = '0;
          if (decode_err(sel_addr, sel_we)) begin
            state_d = ERROR;
          end else begin
            state_d  = ACCESS;
            mem_rd_d = !sel_we;
            mem_wr_d = sel_we;
          end
        end
      end

      ACCESS: begin
        // mfc takes priority over a timeout landing on the same edge.
        if (mfc) begin
          state_d     = IDLE;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          rsp_rdata_d = mem_wr_q ? 32'h0 : mem_rdata;
          if_done_d   = !is_ls_q;
          ls_done_d   = is_ls_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = IDLE;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          if_done_d   = !is_ls_q;
          ls_done_d   = is_ls_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ERROR: begin
        state_d     = IDLE;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b1;
        if_done_d   = !is_ls_q;
        ls_done_d   = is_ls_q;
      end

      default: state_d = IDLE;
    endcase
  end

  // All state and outputs are registered; reset drops the strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b0;
      is_ls_q       <= 1'b0;
      cnt_q         <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_address_q <= 32'h0;
      mem_wdata_q   <= 32'h0;
      if_done_q     <= 1'b0;
      ls_done_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      is_ls_q       <= is_ls_d;
      cnt_q         <= cnt_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      if_done_q     <= if_done_d;
      ls_done_q     <= ls_done_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign if_done     = if_done_q;
  assign ls_done     = ls_done_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator
// Directed bench for mem_initiator with a small bus responder and a
// scoreboard of expected completions. Expected entries are pushed as each
// request is driven; a monitor pops and compares them on every done pulse
// and checks bus address/direction/data while a strobe is high.
module tb_mem_initiator;

  typedef struct {
    logic        is_ls;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          strobe_len;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        if_done;
  logic        ls_done;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        mfc;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  int          strobe_cnt;

  // Responder controls
  logic        mfc_en;
  int          mfc_delay;
  logic [31:0] resp_data;
  int          resp_wait;

  mem_initiator #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .ls_req      (ls_req),
    .ls_we       (ls_we),
    .ls_addr     (ls_addr),
    .ls_wdata    (ls_wdata),
    .if_done     (if_done),
    .ls_done     (ls_done),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_rdata   (mem_rdata),
    .mfc         (mfc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for a done pulse; returns the number of negedges taken.
  task automatic waitDone(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(if_done || ls_done) && cyc < 40);
  endtask

  function automatic exp_t mkExp(input bit is_ls, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit err, input int slen,
                                 input logic [31:0] rdata);
    exp_t e;
    e.is_ls      = is_ls;
    e.we         = we;
    e.addr       = addr;
    e.wdata      = wdata;
    e.err        = err;
    e.strobe_len = slen;
    e.rdata      = rdata;
    return e;
  endfunction

  // Drives one request from a negedge, records its expected outcome and
  // releases the request on the negedge its done pulse is seen.
  task automatic applyStimulus(input string tag, input bit is_ls, input bit we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit err, input int slen, input logic [31:0] rdata,
                               input int lat);
    int cyc;
    if (is_ls) begin
      ls_req   = 1'b1;
      ls_we    = we;
      ls_addr  = addr;
      ls_wdata = wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = addr;
    end
    sb.push_back(mkExp(is_ls, we, addr, is_ls ? wdata : 32'h0, err, slen, rdata));
    waitDone(cyc);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(lat));
    if (is_ls) ls_req = 1'b0;
    else       if_req = 1'b0;
  endtask

  // Bus responder: raises mfc mfc_delay cycles into a strobe.
  initial begin
    mfc       = 1'b0;
    mem_rdata = 32'h0;
    resp_wait = 0;
    forever begin
      @(negedge clk);
      if ((mem_rd || mem_wr) && mfc_en) begin
        if (resp_wait == mfc_delay) begin
          mfc       = 1'b1;
          mem_rdata = resp_data;
        end else begin
          mfc       = 1'b0;
          mem_rdata = 32'h0;
        end
        resp_wait++;
      end else begin
        mfc       = 1'b0;
        mem_rdata = 32'h0;
        resp_wait = 0;
      end
    end
  end

  // Monitor: bus checks while strobing, scoreboard pop on each done.
  initial begin
    exp_t e;
    strobe_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        strobe_cnt = 0;
      end else begin
        if (mem_rd || mem_wr) begin
          strobe_cnt++;
          checkOutput("strobe_excl", 32'(mem_rd & mem_wr), 32'h0);
          if (sb.size() == 0) begin
            checkOutput("unexpected_strobe", 32'({mem_rd, mem_wr}), 32'h0);
          end else begin
            checkOutput("bus_addr", mem_address, sb[0].addr);
            checkOutput("bus_dir", 32'(mem_wr), 32'(sb[0].we));
            if (sb[0].we) checkOutput("bus_wdata", mem_wdata, sb[0].wdata);
          end
        end
        if (if_done || ls_done) begin
          checkOutput("done_overlap", 32'(if_done & ls_done), 32'h0);
          checkOutput("strobe_in_done", 32'({mem_rd, mem_wr}), 32'h0);
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'({if_done, ls_done}), 32'h0);
          end else begin
            e = sb.pop_front();
            checkOutput("done_port", 32'({if_done, ls_done}), 32'({!e.is_ls, e.is_ls}));
            checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
            checkOutput("rsp_rdata", rsp_rdata, e.rdata);
            checkOutput("strobe_len", 32'(strobe_cnt), 32'(e.strobe_len));
          end
          strobe_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    rst_n     = 1'b0;
    mfc_en    = 1'b1;
    mfc_delay = 0;
    resp_data = 32'h0BAD_F00D;
    // Both ports request from reset: fetch read, load/store write.
    if_req    = 1'b1;
    if_addr   = 32'h0000_0040;
    ls_req    = 1'b1;
    ls_we     = 1'b1;
    ls_addr   = 32'h1000_0000;
    ls_wdata  = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'h0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'h0);
    checkOutput("rst_if_done", 32'(if_done), 32'h0);
    checkOutput("rst_ls_done", 32'(ls_done), 32'h0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_mem_address", mem_address, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);

    $display("[TB] contended round-robin from reset");
    sb.push_back(mkExp(1'b1, 1'b1, 32'h1000_0000, 32'hCAFE_F00D, 1'b0, 1, 32'h0));
    sb.push_back(mkExp(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1, 32'h0BAD_F00D));
    sb.push_back(mkExp(1'b1, 1'b1, 32'h1000_0000, 32'hCAFE_F00D, 1'b0, 1, 32'h0));
    sb.push_back(mkExp(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1, 32'h0BAD_F00D));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitDone(cyc);
      checkOutput("rr_gap", 32'(cyc), 32'd2);
      if (i == 2) ls_req = 1'b0;
      if (i == 3) if_req = 1'b0;
    end

    $display("[TB] single accesses");
    resp_data = 32'hDEAD_BEEF;
    applyStimulus("fetch", 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1, 32'hDEAD_BEEF, 2);
    mfc_delay = 3;
    applyStimulus("store_wait", 1'b1, 1'b1, 32'h1000_0004, 32'h1234_5678, 1'b0, 4, 32'h0, 5);
    mfc_delay = 1;
    resp_data = 32'h5A5A_1234;
    applyStimulus("load_csr_top", 1'b1, 1'b0, 32'h0001_FFFC, 32'h0, 1'b0, 2, 32'h5A5A_1234, 3);
    mfc_delay = 0;
    resp_data = 32'h7777_0001;
    applyStimulus("load_map_top", 1'b1, 1'b0, 32'hDFFF_FFFC, 32'h0, 1'b0, 1, 32'h7777_0001, 2);

    $display("[TB] timeout");
    mfc_en = 1'b0;
    applyStimulus("timeout", 1'b1, 1'b0, 32'h2000_0000, 32'h0, 1'b1, 8, 32'h0, 9);

    $display("[TB] decode errors");
    applyStimulus("err_reserved", 1'b1, 1'b0, 32'h0002_0000, 32'h0, 1'b1, 0, 32'h0, 2);
    applyStimulus("err_high", 1'b1, 1'b0, 32'hE000_0000, 32'h0, 1'b1, 0, 32'h0, 2);
    applyStimulus("err_ro_write", 1'b1, 1'b1, 32'h0000_0100, 32'h1111_2222, 1'b1, 0, 32'h0, 2);
    applyStimulus("err_misalign", 1'b0, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 0, 32'h0, 2);
    applyStimulus("err_ls_misalign", 1'b1, 1'b0, 32'h1000_0001, 32'h0, 1'b1, 0, 32'h0, 2);

    $display("[TB] reset during access");
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h2000_0000;
    sb.push_back(mkExp(1'b1, 1'b0, 32'h2000_0000, 32'h0, 1'b1, 8, 32'h0));
    @(negedge clk);
    checkOutput("abort_strobe_up", 32'(mem_rd), 32'h1);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    ls_req = 1'b0;
    #1;
    checkOutput("abort_strobe_drop", 32'({mem_rd, mem_wr}), 32'h0);
    @(negedge clk);
    sb.delete();
    repeat (2) @(negedge clk);
    mfc_en    = 1'b1;
    resp_data = 32'h0000_ABCD;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0080;
    ls_req    = 1'b1;
    ls_we     = 1'b0;
    ls_addr   = 32'h1000_0010;
    sb.push_back(mkExp(1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b0, 1, 32'h0000_ABCD));
    sb.push_back(mkExp(1'b0, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 1, 32'h0000_ABCD));
    rst_n = 1'b1;
    waitDone(cyc);
    checkOutput("post_rst_ls_first_latency", 32'(cyc), 32'd2);
    ls_req = 1'b0;
    waitDone(cyc);
    checkOutput("post_rst_if_latency", 32'(cyc), 32'd2);
    if_req = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
